// File: rtl/router_pkg.sv
// Shared definitions for the router packet source: field widths, the
// reserved destination address and the packet-formatting FSM states.
package router_pkg;

  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;
  localparam int DATA_W = 8;

  // Destination port 3 does not exist on the router.
  localparam logic [ADDR_W-1:0] ILLEGAL_ADDR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    PARITY,
    GAP
  } state_t;

  // Header byte layout expected by the router: length in the upper bits,
  // destination port in the lower two bits.
  function automatic logic [DATA_W-1:0] make_header(input logic [LEN_W-1:0]  len,
                                                    input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_src_fifo.sv
// Synchronous first-word-fall-through payload FIFO. The head byte is always
// visible on o_head while the FIFO is non-empty; a pop advances to the next.
module router_src_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CNT_W = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic              o_ready,
  output logic [CNT_W-1:0]  o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  // Pointers wrap at DEPTH-1 so non-power-of-two depths also work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_ready = (r_count < CNT_W'(DEPTH));
  assign w_push  = i_push && o_ready;
  assign w_pop   = i_pop && (r_count != '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Pointer and occupancy bookkeeping; simultaneous push and pop keeps the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/router_pkt_source.sv
// Packet source feeding the router input port. A command is only accepted
// once its whole payload is buffered, so pkt_valid never bubbles inside a
// packet. Emits header, payload and a trailing parity byte, honouring busy.
module router_pkt_source
  import router_pkg::*;
#(
  parameter int PL_DEPTH   = 64,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic [DATA_W-1:0] pl_data,
  input  logic              busy,
  output logic              pkt_valid,
  output logic [DATA_W-1:0] pkt_data,
  output logic              pkt_done,
  output logic              err_addr,
  output logic [6:0]        fifo_count
);

  localparam int CNT_W = 7;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_pkt_valid,  w_pkt_valid_nxt;
  logic [DATA_W-1:0] r_pkt_data,   w_pkt_data_nxt;
  logic              r_pkt_done,   w_pkt_done_nxt;
  logic              r_err_addr,   w_err_addr_nxt;
  logic [DATA_W-1:0] r_parity,     w_parity_nxt;
  logic [LEN_W-1:0]  r_len,        w_len_nxt;
  logic [LEN_W-1:0]  r_remaining,  w_remaining_nxt;
  logic [GAP_W-1:0]  r_gap_cnt,    w_gap_cnt_nxt;

  logic              w_cmd_ready;
  logic              w_cmd_illegal;
  logic [LEN_W-1:0]  w_rem_dec;
  logic              w_fifo_pop;
  logic [DATA_W-1:0] w_fifo_head;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_pl_ready;

  router_src_fifo #(
    .DEPTH (PL_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (pl_valid),
    .i_data  (pl_data),
    .i_pop   (w_fifo_pop),
    .o_head  (w_fifo_head),
    .o_ready (w_pl_ready),
    .o_count (w_fifo_count)
  );

  // Illegal commands are always consumable; legal ones wait for their payload.
  assign w_cmd_illegal = (cmd_addr == ILLEGAL_ADDR);
  assign w_cmd_ready   = (r_state == IDLE) && cmd_valid &&
                         (w_cmd_illegal || (w_fifo_count >= {1'b0, cmd_len}));
  assign w_rem_dec     = r_remaining - LEN_W'(1);

  // Next-state and next-output logic; a byte advances only when busy is low.
  always_comb begin
    w_state_nxt     = r_state;
    w_pkt_valid_nxt = r_pkt_valid;
    w_pkt_data_nxt  = r_pkt_data;
    w_pkt_done_nxt  = 1'b0;
    w_err_addr_nxt  = 1'b0;
    w_parity_nxt    = r_parity;
    w_len_nxt       = r_len;
    w_remaining_nxt = r_remaining;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_fifo_pop      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cmd_ready) begin
          if (w_cmd_illegal) begin
            w_err_addr_nxt = 1'b1;
          end else begin
            w_pkt_valid_nxt = 1'b1;
            w_pkt_data_nxt  = make_header(cmd_len, cmd_addr);
            w_parity_nxt    = make_header(cmd_len, cmd_addr);
            w_len_nxt       = cmd_len;
            w_state_nxt     = HEADER;
          end
        end
      end
      HEADER: begin
        if (!busy) begin
          if (r_len == '0) begin
            w_pkt_valid_nxt = 1'b0;
            w_pkt_data_nxt  = r_parity;
            w_state_nxt     = PARITY;
          end else begin
            w_fifo_pop      = 1'b1;
            w_pkt_data_nxt  = w_fifo_head;
            w_parity_nxt    = r_parity ^ w_fifo_head;
            w_remaining_nxt = r_len;
            w_state_nxt     = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (!busy) begin
          w_remaining_nxt = w_rem_dec;
          if (w_rem_dec == '0) begin
            w_pkt_valid_nxt = 1'b0;
            w_pkt_data_nxt  = r_parity;
            w_state_nxt     = PARITY;
          end else begin
            w_fifo_pop     = 1'b1;
            w_pkt_data_nxt = w_fifo_head;
            w_parity_nxt   = r_parity ^ w_fifo_head;
          end
        end
      end
      PARITY: begin
        if (!busy) begin
          w_pkt_done_nxt = 1'b1;
          w_pkt_data_nxt = '0;
          w_gap_cnt_nxt  = '0;
          w_state_nxt    = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          w_state_nxt = IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset aborts any packet in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pkt_valid <= 1'b0;
      r_pkt_data  <= '0;
      r_pkt_done  <= 1'b0;
      r_err_addr  <= 1'b0;
      r_parity    <= '0;
      r_len       <= '0;
      r_remaining <= '0;
      r_gap_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pkt_valid <= w_pkt_valid_nxt;
      r_pkt_data  <= w_pkt_data_nxt;
      r_pkt_done  <= w_pkt_done_nxt;
      r_err_addr  <= w_err_addr_nxt;
      r_parity    <= w_parity_nxt;
      r_len       <= w_len_nxt;
      r_remaining <= w_remaining_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
    end
  end

  assign cmd_ready  = w_cmd_ready;
  assign pl_ready   = w_pl_ready;
  assign pkt_valid  = r_pkt_valid;
  assign pkt_data   = r_pkt_data;
  assign pkt_done   = r_pkt_done;
  assign err_addr   = r_err_addr;
  assign fifo_count = w_fifo_count;

endmodule

// File: tb/tb_router_pkt_source.sv
// Directed bench for router_pkt_source: full packets, busy stalls, zero-length
// packet, illegal address, waiting for payload, FIFO full and mid-packet reset.
module tb_router_pkt_source;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_addr;
  logic [5:0] cmd_len;
  logic       pl_valid;
  logic       pl_ready;
  logic [7:0] pl_data;
  logic       busy;
  logic       pkt_valid;
  logic [7:0] pkt_data;
  logic       pkt_done;
  logic       err_addr;
  logic [6:0] fifo_count;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         seq   = 0;
  logic [7:0] q[$];

  always #5 clock = ~clock;

  router_pkt_source #(
    .PL_DEPTH   (64),
    .GAP_CYCLES (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .pl_valid   (pl_valid),
    .pl_ready   (pl_ready),
    .pl_data    (pl_data),
    .busy       (busy),
    .pkt_valid  (pkt_valid),
    .pkt_data   (pkt_data),
    .pkt_done   (pkt_done),
    .err_addr   (err_addr),
    .fifo_count (fifo_count)
  );

  task automatic step;
    @(negedge clock);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push n bytes on consecutive cycles, recording them in the expected queue.
  task automatic push_bytes(input int n, input bit rnd);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      if (rnd) b = 8'($urandom_range(0, 255));
      else     b = 8'(seq * 37 + 11);
      seq++;
      pl_valid = 1'b1;
      pl_data  = b;
      q.push_back(b);
      step();
    end
    pl_valid = 1'b0;
  endtask

  // Issue a command and follow the packet byte by byte. busy_at/abort_at
  // are payload indices (-1 disables) where a stall or a reset is applied.
  task automatic send_pkt(input logic [1:0] addr, input logic [5:0] len,
                          input logic [7:0] exp_hdr, input int busy_at,
                          input int busy_cyc, input int abort_at);
    logic [7:0] par;
    logic [7:0] b;
    int         waited;
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = len;
    #1;
    waited = 0;
    while (!cmd_ready && waited < 200) begin
      step();
      #1;
      waited++;
    end
    chk1("cmd_ready", cmd_ready, 1'b1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    step();
    cmd_valid = 1'b0;
    chk1("hdr_valid", pkt_valid, 1'b1);
    chk8("hdr_data", pkt_data, exp_hdr);
    par = exp_hdr;
    step();
    for (int i = 0; i < int'(len); i++) begin
      b   = q.pop_front();
      par = par ^ b;
      chk1("pl_valid_out", pkt_valid, 1'b1);
      chk8("pl_byte", pkt_data, b);
      if (i == abort_at) begin
        reset = 1'b1;
        step();
        chk1("abort_valid", pkt_valid, 1'b0);
        chk8("abort_count", {1'b0, fifo_count}, 8'd0);
        chk1("abort_done", pkt_done, 1'b0);
        chk8("abort_data", pkt_data, 8'h00);
        reset = 1'b0;
        q.delete();
        repeat (3) begin
          step();
          chk1("abort_no_done", pkt_done, 1'b0);
          chk1("abort_no_valid", pkt_valid, 1'b0);
        end
        return;
      end
      if (i == busy_at) begin
        busy = 1'b1;
        repeat (busy_cyc) begin
          step();
          chk1("busy_hold_valid", pkt_valid, 1'b1);
          chk8("busy_hold_data", pkt_data, b);
        end
        busy = 1'b0;
      end
      step();
    end
    chk1("par_valid", pkt_valid, 1'b0);
    chk8("par_data", pkt_data, par);
    chk1("par_done_early", pkt_done, 1'b0);
    step();
    chk1("done_pulse", pkt_done, 1'b1);
    chk1("done_valid", pkt_valid, 1'b0);
    chk8("done_data", pkt_data, 8'h00);
    chk8("done_count", {1'b0, fifo_count}, 8'(q.size()));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = 2'd0;
    cmd_len   = 6'd0;
    pl_valid  = 1'b0;
    pl_data   = 8'h00;
    busy      = 1'b0;
    repeat (3) step();
    chk1("rst_valid", pkt_valid, 1'b0);
    chk8("rst_data", pkt_data, 8'h00);
    chk1("rst_done", pkt_done, 1'b0);
    chk1("rst_err", err_addr, 1'b0);
    chk8("rst_count", {1'b0, fifo_count}, 8'd0);
    reset = 1'b0;
    step();

    // 16 random bytes to port 1
    push_bytes(16, 1'b1);
    chk8("t1_count", {1'b0, fifo_count}, 8'd16);
    send_pkt(2'd1, 6'd16, 8'h41, -1, 0, -1);

    // port 2, 14 bytes, 3-cycle stall on payload byte 6
    push_bytes(14, 1'b0);
    send_pkt(2'd2, 6'd14, 8'h3A, 6, 3, -1);

    // zero-length packet offered during the gap: refused for two cycles
    cmd_valid = 1'b1;
    cmd_addr  = 2'd0;
    cmd_len   = 6'd0;
    #1;
    chk1("gap0_ready", cmd_ready, 1'b0);
    step();
    #1;
    chk1("gap1_ready", cmd_ready, 1'b0);
    step();
    #1;
    chk1("gap_end_ready", cmd_ready, 1'b1);
    send_pkt(2'd0, 6'd0, 8'h00, -1, 0, -1);
    repeat (3) step();

    // illegal address with 5 bytes buffered
    push_bytes(5, 1'b0);
    cmd_valid = 1'b1;
    cmd_addr  = 2'd3;
    cmd_len   = 6'd5;
    #1;
    chk1("ill_ready", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    chk1("ill_err", err_addr, 1'b1);
    chk1("ill_valid", pkt_valid, 1'b0);
    chk8("ill_count", {1'b0, fifo_count}, 8'd5);
    step();
    chk1("ill_err_pulse", err_addr, 1'b0);
    chk1("ill_valid2", pkt_valid, 1'b0);
    chk8("ill_count2", {1'b0, fifo_count}, 8'd5);

    // len 20 waits until the 20th byte is buffered
    push_bytes(5, 1'b0);
    cmd_valid = 1'b1;
    cmd_addr  = 2'd1;
    cmd_len   = 6'd20;
    #1;
    chk1("wait_ready10", cmd_ready, 1'b0);
    for (int k = 0; k < 10; k++) begin
      pl_valid = 1'b1;
      pl_data  = 8'(seq * 37 + 11);
      q.push_back(8'(seq * 37 + 11));
      seq++;
      step();
      pl_valid = 1'b0;
      #1;
      chk1("wait_ready", cmd_ready, (k == 9) ? 1'b1 : 1'b0);
    end
    send_pkt(2'd1, 6'd20, 8'h51, -1, 0, -1);
    repeat (3) step();

    // fill the FIFO completely
    chk1("fill_ready0", pl_ready, 1'b1);
    push_bytes(63, 1'b0);
    chk1("fill_ready63", pl_ready, 1'b1);
    push_bytes(1, 1'b0);
    chk8("fill_count", {1'b0, fifo_count}, 8'd64);
    chk1("fill_ready64", pl_ready, 1'b0);

    // reset while payload byte 5 is on the bus
    send_pkt(2'd1, 6'd16, 8'h41, -1, 0, 5);

    // a clean 4-byte packet afterwards
    push_bytes(4, 1'b0);
    send_pkt(2'd2, 6'd4, 8'h12, -1, 0, -1);
    chk8("final_count", {1'b0, fifo_count}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/router_pkt_source.md
Name: router_pkt_source

Overview:
- Upstream packet-formatting stage that drives the router input port (pkt_valid / data / busy).
- Takes a packet command (address, length) and a payload byte stream from the host side, buffers the payload, and emits header, payload and parity with the router's byte protocol.
- Honours router busy back-pressure.
- Guarantees that pkt_valid never bubbles mid-packet by starting a packet only once its whole payload is buffered.

Parameters:
- PL_DEPTH, 64: payload FIFO depth in bytes; must be ≥ 63 (max cmd_len).
- GAP_CYCLES, 2: idle cycles forced after each parity byte, before the next header.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  packet command present
- cmd_ready  out  1  command consumed this cycle (valid & ready)
- cmd_addr  in  2  destination port; 0..2 legal, 3 illegal
- cmd_len  in  6  payload length in bytes, 0..63
- pl_valid  in  1  payload byte present
- pl_ready  out  1  payload FIFO can accept a byte
- pl_data  in  8  payload byte
- busy  in  1  router busy; presented byte is held while high
- pkt_valid  out  1  to router: high during header and payload bytes
- pkt_data  out  8  to router data input
- pkt_done  out  1  one-cycle pulse when a parity byte is consumed
- err_addr  out  1  one-cycle pulse when an illegal-address command is dropped
- fifo_count  out  7  payload bytes currently buffered

Behaviour:
- Reset values: all outputs 0 (pkt_valid, pkt_data, pkt_done, err_addr, fifo_count); FIFO emptied; FSM in IDLE; parity register cleared.
- Reset mid-packet aborts the packet. pkt_valid=0 from the cycle after the reset edge, and no parity byte is sent.
- Consume rule: the byte on pkt_data is consumed at a rising edge where busy==0. While busy==1, pkt_valid and pkt_data hold steady.
- pkt_valid and pkt_data are registered outputs.
- Payload FIFO:
  - First-word-fall-through.
  - pl_ready = (fifo_count < PL_DEPTH).
  - Push when pl_valid & pl_ready.
  - A simultaneous push and pop leaves the count unchanged; pointers wrap modulo PL_DEPTH.
- Header byte = {cmd_len, cmd_addr}.
- Parity = XOR of the header and every payload byte, accumulated as each byte is loaded.
- FSM states:
  - IDLE:
    - cmd_ready = cmd_valid & (cmd_addr==3 | fifo_count ≥ cmd_len).
    - Illegal address: consume the command, pulse err_addr next cycle, leave the FIFO untouched, stay in IDLE.
    - Legal command: latch the length, load the header into pkt_data with pkt_valid=1 (visible the cycle after acceptance), go to HEADER.
  - HEADER: on consume, if len==0 load parity (pkt_valid=0) and go to PARITY; otherwise pop the FIFO head into pkt_data and go to PAYLOAD with remaining = len.
  - PAYLOAD:
    - On each consume, decrement remaining.
    - If remaining becomes 0, load the parity byte with pkt_valid=0 and go to PARITY.
    - Otherwise pop the next FIFO byte.
  - PARITY: on consume, pulse pkt_done, drive pkt_data=0, go to GAP.
  - GAP: pkt_valid=0 for GAP_CYCLES cycles, then IDLE. Commands are not accepted in GAP.
- Since the FIFO holds at least len bytes when a packet starts, the FIFO never underflows during PAYLOAD.
- Host pushes continue during a packet.
- Minimum packet time with busy low: 1 (accept) + 1 (header) + len + 1 (parity) + GAP_CYCLES cycles.
- Consuming a command whose len exceeds fifo_count is impossible; the command waits with cmd_ready=0.

Decomposition:
- Shared package router_pkg: ADDR_W=2, LEN_W=6, DATA_W=8, ILLEGAL_ADDR=2'b11, FSM state enum (IDLE, HEADER, PAYLOAD, PARITY, GAP).
- One sub-module, router_src_fifo: synchronous FWFT FIFO with DATA_W and PL_DEPTH, count output and sync reset.
- FSM, parity and gap counter live in router_pkt_source.

Test Plan:
- Push 16 random bytes, then cmd addr=1 len=16, busy=0.
  - Expect header 8'h41 with pkt_valid=1, then the 16 bytes in order, then parity byte with pkt_valid=0, pkt_done pulse.
  - Expect parity == XOR of all 17 bytes and fifo_count back to 0.
- cmd addr=2 len=14 with busy toggled high for 3 cycles mid-payload.
  - Expect pkt_data/pkt_valid frozen during busy, no byte duplicated or lost, header 8'h3A.
- cmd addr=0 len=0.
  - Expect header 8'h00, then parity 8'h00 with pkt_valid=0, pkt_done; total 3 cycles from acceptance to pkt_done.
- cmd addr=3 len=5 with 5 bytes buffered.
  - Expect cmd_ready=1, err_addr pulse, no pkt_valid, fifo_count stays 5.
- cmd addr=1 len=20 with only 10 bytes buffered.
  - Expect cmd_ready=0 until the 20th byte is pushed, then header 8'h51.
  - Push 64 bytes: pl_ready=0 at fifo_count=64.
- Assert reset during byte 5 of a 16-byte payload.
  - Expect pkt_valid=0 the next cycle, fifo_count=0, no pkt_done.
  - A following 4-byte packet is sent correctly.
